// File: rtl/snn_pkg.sv
// Shared definitions for the SNN front end: image geometry and loader FSM states.
package snn_pkg;

  localparam int unsigned NUM_PIXELS = 784;
  localparam int unsigned IMG_BYTES  = NUM_PIXELS / 8;

  typedef enum logic [1:0] {
    LOAD,
    START,
    WAIT_DONE
  } loader_state_t;

endpackage

// File: rtl/snn_byte_unpacker.sv
// Byte-to-bit unpacker: 8-bit shifter emitting LSB first, with a one-byte pending slot
// so a byte arriving mid-shift is kept and fed in without a bubble.
module snn_byte_unpacker (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       byte_vld,
  input  logic [7:0] byte_in,
  output logic       bit_vld,
  output logic       bit_out,
  output logic       full,
  output logic       drop
);

  logic [7:0] r_shift;
  logic [7:0] r_pend;
  logic       r_shift_full;
  logic       r_pend_full;
  logic [2:0] r_bit_cnt;
  logic       w_last;

  assign w_last  = r_shift_full && (r_bit_cnt == 3'd7);
  assign bit_vld = r_shift_full;
  assign bit_out = r_shift[0];
  assign full    = r_shift_full && r_pend_full;
  // On the last bit the pending byte moves up, so a full slot can still take a byte.
  assign drop    = byte_vld && full && !w_last && !flush;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_shift      <= '0;
      r_pend       <= '0;
      r_shift_full <= 1'b0;
      r_pend_full  <= 1'b0;
      r_bit_cnt    <= '0;
    end else if (w_last) begin
      r_bit_cnt <= '0;
      if (r_pend_full) begin
        r_shift     <= r_pend;
        r_pend_full <= byte_vld;
        if (byte_vld) begin
          r_pend <= byte_in;
        end
      end else begin
        r_shift_full <= byte_vld;
        if (byte_vld) begin
          r_shift <= byte_in;
        end
      end
    end else if (r_shift_full) begin
      r_shift   <= r_shift >> 1;
      r_bit_cnt <= r_bit_cnt + 3'd1;
      if (byte_vld && !r_pend_full) begin
        r_pend      <= byte_in;
        r_pend_full <= 1'b1;
      end
    end else if (byte_vld) begin
      r_shift      <= byte_in;
      r_shift_full <= 1'b1;
      r_bit_cnt    <= '0;
    end
  end

endmodule

// File: rtl/snn_input_loader.sv
// Loads a packed 1-bit image into the input RAM, kicks snn_core, and latches its result.
module snn_input_loader
  import snn_pkg::*;
#(
  parameter int unsigned NUM_PIXELS = snn_pkg::NUM_PIXELS,
  parameter int unsigned ADDR_W     = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_vld,
  input  logic [7:0]        rx_data,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_data,
  output logic              core_start,
  input  logic              core_done,
  input  logic [3:0]        core_digit,
  output logic [3:0]        digit,
  output logic              result_vld,
  output logic              busy,
  output logic              overrun
);

  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(NUM_PIXELS - 1);

  loader_state_t     r_state;
  logic [ADDR_W-1:0] r_pix_cnt;
  logic              r_ram_we;
  logic [ADDR_W-1:0] r_ram_addr;
  logic              r_ram_data;
  logic              r_core_start;
  logic [3:0]        r_digit;
  logic              r_result_vld;
  logic              r_busy;
  logic              r_overrun;

  logic w_byte_vld;
  logic w_bit_vld;
  logic w_bit_out;
  logic w_unp_full;
  logic w_drop;
  logic w_flush;

  assign w_byte_vld = rx_vld && (r_state == LOAD);
  // The final pixel write ends the image; anything still buffered belongs to no image.
  assign w_flush    = (r_state == LOAD) && w_bit_vld && (r_pix_cnt == LAST_PIX);

  snn_byte_unpacker u_unpacker (
    .clk      (clk),
    .rst      (rst),
    .flush    (w_flush),
    .byte_vld (w_byte_vld),
    .byte_in  (rx_data),
    .bit_vld  (w_bit_vld),
    .bit_out  (w_bit_out),
    .full     (w_unp_full),
    .drop     (w_drop)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= LOAD;
      r_pix_cnt    <= '0;
      r_ram_we     <= 1'b0;
      r_ram_addr   <= '0;
      r_ram_data   <= 1'b0;
      r_core_start <= 1'b0;
      r_digit      <= '0;
      r_result_vld <= 1'b0;
      r_busy       <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_ram_we     <= 1'b0;
      r_core_start <= 1'b0;
      r_result_vld <= 1'b0;
      if (w_drop || (rx_vld && (r_state != LOAD))) begin
        r_overrun <= 1'b1;
      end
      case (r_state)
        LOAD: begin
          if (w_bit_vld) begin
            r_ram_we   <= 1'b1;
            r_ram_addr <= r_pix_cnt;
            r_ram_data <= w_bit_out;
            if (r_pix_cnt == LAST_PIX) begin
              r_pix_cnt <= '0;
              r_state   <= START;
              r_busy    <= 1'b1;
            end else begin
              r_pix_cnt <= r_pix_cnt + ADDR_W'(1);
            end
          end
        end
        START: begin
          r_core_start <= 1'b1;
          r_state      <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (core_done) begin
            r_digit      <= core_digit;
            r_result_vld <= 1'b1;
            r_state      <= LOAD;
            r_busy       <= 1'b0;
          end
        end
        default: begin
          r_state <= LOAD;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assert property (@(posedge clk) disable iff (rst) w_drop |-> w_unp_full);

  assign ram_we     = r_ram_we;
  assign ram_addr   = r_ram_addr;
  assign ram_data   = r_ram_data;
  assign core_start = r_core_start;
  assign digit      = r_digit;
  assign result_vld = r_result_vld;
  assign busy       = r_busy;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_snn_input_loader.sv
// Bench for snn_input_loader: vector table, directed image sequences, and randomized
// traffic checked cycle by cycle against a pixel-queue reference model.
module tb_snn_input_loader;

  localparam int NPIX = 784;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_vld;
  logic [7:0] rx_data;
  logic       ram_we;
  logic [9:0] ram_addr;
  logic       ram_data;
  logic       core_start;
  logic       core_done;
  logic [3:0] core_digit;
  logic [3:0] digit;
  logic       result_vld;
  logic       busy;
  logic       overrun;

  always #5 clk = ~clk;

  snn_input_loader #(.NUM_PIXELS(784), .ADDR_W(10)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_vld     (rx_vld),
    .rx_data    (rx_data),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_data   (ram_data),
    .core_start (core_start),
    .core_done  (core_done),
    .core_digit (core_digit),
    .digit      (digit),
    .result_vld (result_vld),
    .busy       (busy),
    .overrun    (overrun)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: pixels waiting to be written, in order; at most two bytes in flight.
  logic mq[$];
  int   m_pix = 0, m_ph = 0, m_addr = 0;
  logic m_we = 0, m_data = 0, m_start = 0, m_rvld = 0, m_busy = 0, m_ovr = 0;
  logic [3:0] m_digit = '0;

  int we_cnt = 0, we_run = 0, we_maxrun = 0, n_start = 0, burst = 0;
  bit burst_mode = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_step(input logic r, input logic v, input logic [7:0] d,
                                     input logic dn, input logic [3:0] dg);
    bit flushed;
    flushed = 0;
    if (r) begin
      mq.delete();
      m_pix = 0; m_ph = 0; m_we = 0; m_addr = 0; m_data = 0;
      m_start = 0; m_digit = '0; m_rvld = 0; m_busy = 0; m_ovr = 0;
      return;
    end
    m_we = 0; m_start = 0; m_rvld = 0;
    case (m_ph)
      0: begin
        if (mq.size() > 0) begin
          m_data = mq.pop_front();
          m_we   = 1;
          m_addr = m_pix;
          if (m_pix == NPIX - 1) begin
            m_pix = 0; mq.delete(); m_ph = 1; flushed = 1;
          end else begin
            m_pix++;
          end
        end
        if (v && !flushed) begin
          if (mq.size() <= 8) begin
            for (int i = 0; i < 8; i++) mq.push_back(d[i]);
          end else begin
            m_ovr = 1;
          end
        end
      end
      1: begin
        m_start = 1; m_ph = 2;
        if (v) m_ovr = 1;
      end
      default: begin
        if (v) m_ovr = 1;
        if (dn) begin
          m_digit = dg; m_rvld = 1; m_ph = 0;
        end
      end
    endcase
    m_busy = (m_ph != 0);
  endfunction

  task automatic cyc(input logic r, input logic v, input logic [7:0] d,
                     input logic dn, input logic [3:0] dg);
    rst = r; rx_vld = v; rx_data = d; core_done = dn; core_digit = dg;
    @(posedge clk);
    model_step(r, v, d, dn, dg);
    #1;
    chk("ram_we", int'(ram_we), int'(m_we));
    if (m_we) begin
      chk("ram_addr", int'(ram_addr), m_addr);
      chk("ram_data", int'(ram_data), int'(m_data));
    end
    chk("core_start", int'(core_start), int'(m_start));
    chk("result_vld", int'(result_vld), int'(m_rvld));
    chk("digit", int'(digit), int'(m_digit));
    chk("busy", int'(busy), int'(m_busy));
    chk("overrun", int'(overrun), int'(m_ovr));
    if (core_start) n_start++;
    if (ram_we) begin
      we_cnt++; we_run++; burst++;
      if (we_run > we_maxrun) we_maxrun = we_run;
    end else begin
      if (burst_mode && burst != 0) chk("burst_len", burst, 8);
      we_run = 0; burst = 0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 8'h00, 0, 4'd0);
  endtask

  task automatic clear_stats();
    we_cnt = 0; we_run = 0; we_maxrun = 0; n_start = 0; burst = 0;
  endtask

  task automatic wait_start(input string name);
    int k;
    k = 0;
    while (n_start == 0 && k < 40) begin
      idle(1);
      k++;
    end
    chk(name, n_start, 1);
  endtask

  typedef struct {
    logic       vld;
    logic [7:0] data;
    logic       dn;
    logic [3:0] dg;
    logic       we;
    int         addr;
    logic       dat;
    logic       ovr;
  } vec_t;

  vec_t tbl[14];

  initial begin
    // Image start: two adjacent bytes are kept, a third one is dropped, done is ignored in LOAD.
    tbl[0]  = '{1'b1, 8'h0F, 1'b0, 4'd0, 1'b0, 0,  1'b0, 1'b0};
    tbl[1]  = '{1'b1, 8'hF0, 1'b0, 4'd0, 1'b1, 0,  1'b1, 1'b0};
    tbl[2]  = '{1'b1, 8'h33, 1'b0, 4'd0, 1'b1, 1,  1'b1, 1'b1};
    tbl[3]  = '{1'b0, 8'h00, 1'b1, 4'd7, 1'b1, 2,  1'b1, 1'b1};
    tbl[4]  = '{1'b0, 8'h00, 1'b0, 4'd0, 1'b1, 3,  1'b1, 1'b1};
    tbl[5]  = '{1'b0, 8'h00, 1'b0, 4'd0, 1'b1, 4,  1'b0, 1'b1};
    tbl[6]  = '{1'b0, 8'h00, 1'b0, 4'd0, 1'b1, 5,  1'b0, 1'b1};
    tbl[7]  = '{1'b0, 8'h00, 1'b0, 4'd0, 1'b1, 6,  1'b0, 1'b1};
    tbl[8]  = '{1'b0, 8'h00, 1'b0, 4'd0, 1'b1, 7,  1'b0, 1'b1};
    tbl[9]  = '{1'b0, 8'h00, 1'b0, 4'd0, 1'b1, 8,  1'b0, 1'b1};
    tbl[10] = '{1'b0, 8'h00, 1'b0, 4'd0, 1'b1, 9,  1'b0, 1'b1};
    tbl[11] = '{1'b0, 8'h00, 1'b0, 4'd0, 1'b1, 10, 1'b0, 1'b1};
    tbl[12] = '{1'b0, 8'h00, 1'b0, 4'd0, 1'b1, 11, 1'b0, 1'b1};
    tbl[13] = '{1'b0, 8'h00, 1'b0, 4'd0, 1'b1, 12, 1'b1, 1'b1};

    cyc(1, 0, 8'h00, 0, 4'd0);
    cyc(1, 0, 8'h00, 0, 4'd0);
    chk("rst_ram_we", int'(ram_we), 0);
    chk("rst_ram_addr", int'(ram_addr), 0);
    chk("rst_ram_data", int'(ram_data), 0);
    chk("rst_core_start", int'(core_start), 0);
    chk("rst_digit", int'(digit), 0);
    chk("rst_result_vld", int'(result_vld), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_overrun", int'(overrun), 0);

    for (int i = 0; i < 14; i++) begin
      cyc(0, tbl[i].vld, tbl[i].data, tbl[i].dn, tbl[i].dg);
      chk($sformatf("tbl%0d_we", i), int'(ram_we), int'(tbl[i].we));
      if (tbl[i].we) begin
        chk($sformatf("tbl%0d_addr", i), int'(ram_addr), tbl[i].addr);
        chk($sformatf("tbl%0d_data", i), int'(ram_data), int'(tbl[i].dat));
      end
      chk($sformatf("tbl%0d_ovr", i), int'(overrun), int'(tbl[i].ovr));
      chk($sformatf("tbl%0d_rvld", i), int'(result_vld), 0);
    end

    // Full A5 image at the byte rate the shifter drains: one gap-free write stream.
    cyc(1, 0, 8'h00, 0, 4'd0);
    clear_stats();
    for (int b = 0; b < 98; b++) begin
      cyc(0, 1, 8'hA5, 0, 4'd0);
      idle(7);
    end
    wait_start("a5_start_seen");
    chk("a5_we_count", we_cnt, 784);
    chk("a5_contiguous", we_maxrun, 784);
    chk("a5_overrun", int'(overrun), 0);
    idle(3);
    chk("a5_single_start", n_start, 1);

    // Byte during WAIT_DONE is dropped; then core_done returns the digit.
    cyc(0, 1, 8'h77, 0, 4'd0);
    chk("wait_rx_overrun", int'(overrun), 1);
    chk("wait_rx_no_we", int'(ram_we), 0);
    idle(1);
    chk("wait_rx_no_we2", int'(ram_we), 0);
    cyc(0, 0, 8'h00, 1, 4'd2);
    chk("done_rvld", int'(result_vld), 1);
    chk("done_digit", int'(digit), 2);
    chk("done_busy", int'(busy), 0);
    cyc(0, 1, 8'h01, 0, 4'd0);
    chk("done_rvld_pulse", int'(result_vld), 0);
    idle(1);
    chk("next_img_we", int'(ram_we), 1);
    chk("next_img_addr0", int'(ram_addr), 0);
    chk("next_img_data", int'(ram_data), 1);

    // Sparse bytes: each produces its own burst of exactly 8 writes.
    cyc(1, 0, 8'h00, 0, 4'd0);
    clear_stats();
    burst_mode = 1;
    for (int b = 0; b < 98; b++) begin
      cyc(0, 1, 8'($urandom), 0, 4'd0);
      idle(19);
    end
    wait_start("sparse_start_seen");
    burst_mode = 0;
    chk("sparse_we_count", we_cnt, 784);
    idle(2);
    cyc(0, 0, 8'h00, 1, 4'd9);
    chk("sparse_digit", int'(digit), 9);

    // Reset mid-image discards the partial image.
    cyc(1, 0, 8'h00, 0, 4'd0);
    for (int b = 0; b < 50; b++) begin
      cyc(0, 1, 8'($urandom), 0, 4'd0);
      idle(7);
    end
    cyc(1, 0, 8'h00, 0, 4'd0);
    clear_stats();
    for (int b = 0; b < 97; b++) begin
      cyc(0, 1, 8'($urandom), 0, 4'd0);
      idle(7);
    end
    idle(12);
    chk("rst_mid_no_early_start", n_start, 0);
    chk("rst_mid_we_count", we_cnt, 97 * 8);
    cyc(0, 1, 8'($urandom), 0, 4'd0);
    wait_start("rst_mid_start_seen");
    idle(2);
    cyc(0, 0, 8'h00, 1, 4'd5);

    // Random traffic, including occasional resets.
    for (int i = 0; i < 4000; i++) begin
      cyc(($urandom_range(0, 999) == 0), ($urandom_range(0, 5) == 0), 8'($urandom),
          ($urandom_range(0, 40) == 0), 4'($urandom_range(0, 9)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
